id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 31 +++
 rtl/id_stage_if.sv | 45 ++++
 rtl/register_file.sv | 51 +++++
 rtl/id_stage.sv | 100 ++++++++++
 tb/tb_id_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, the NOP word and instruction field positions.
// Also holds the small helpers used by the decode and hazard logic.
package id_stage_pkg;

    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // A producer only conflicts when it targets a real register that this instruction reads.
    function automatic logic hazard_match(input logic [4:0] dst,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt);
        return (dst != 5'd0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bus bundle between the fetch/EX/MEM/WB side (master) and the ID stage (slave).
interface id_stage_if;

    logic [31:0] pc_add_out;
    logic [31:0] r_data;
    logic        wb_RegWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_RegWrite;
    logic        ex_MemRead;
    logic [4:0]  ex_write_reg;
    logic        mem_MemRead;
    logic [4:0]  mem_write_reg;

    logic        PCWrite;
    logic        PCSrc;
    logic        Jump;
    logic [31:0] branch_add;
    logic [31:0] jump_add;
    logic [31:0] id_pc_add;
    logic [31:0] id_inst;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] sign_ext;
    logic        id_bubble;

    modport master (
        output pc_add_out, r_data,
        output wb_RegWrite, wb_write_reg, wb_write_data,
        output ex_RegWrite, ex_MemRead, ex_write_reg,
        output mem_MemRead, mem_write_reg,
        input  PCWrite, PCSrc, Jump, branch_add, jump_add,
        input  id_pc_add, id_inst, read_data1, read_data2, sign_ext, id_bubble
    );

    modport slave (
        input  pc_add_out, r_data,
        input  wb_RegWrite, wb_write_reg, wb_write_data,
        input  ex_RegWrite, ex_MemRead, ex_write_reg,
        input  mem_MemRead, mem_write_reg,
        output PCWrite, PCSrc, Jump, branch_add, jump_add,
        output id_pc_add, id_inst, read_data1, read_data2, sign_ext, id_bubble
    );

endinterface

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one write port, $0 hard-wired to zero.
// With ID_BYPASS_EN defined, a same-cycle write is forwarded to matching read ports.
module register_file
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] reg_vals [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_vals[gi] = '0;
            end else begin : g_flop
                logic [31:0] reg_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        reg_q <= '0;
                    end else if (we_i && (waddr_i == 5'(gi))) begin
                        reg_q <= wdata_i;
                    end
                end
                assign reg_vals[gi] = reg_q;
            end
        end
    endgenerate

    always_comb begin
        rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : reg_vals[raddr1_i];
        rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : reg_vals[raddr2_i];
`ifdef ID_BYPASS_EN
        if (we_i && (raddr1_i != 5'd0) && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (raddr2_i != 5'd0) && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

endmodule

// File: rtl/id_stage.sv
// Pipeline ID stage: IF/ID register, register file, hazard stalls, branch/jump resolution.
// Optional write-through of the WB port to the read ports is enabled by defining ID_BYPASS_EN.
module id_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_INST = NOP_WORD
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_ext;
    logic [31:0] rd1, rd2;

    logic is_beq, is_j;
    logic load_use, branch_hazard, stall;
    logic take_branch, take_jump, flush;

    assign opcode  = inst_q[OPC_HI:OPC_LO];
    assign rs      = inst_q[RS_HI:RS_LO];
    assign rt      = inst_q[RT_HI:RT_LO];
    assign imm     = inst_q[IMM_HI:IMM_LO];
    assign target  = inst_q[TGT_HI:TGT_LO];
    assign imm_ext = sign_extend16(imm);

    register_file u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rd1),
        .rdata2_o (rd2),
        .we_i     (bus.wb_RegWrite),
        .waddr_i  (bus.wb_write_reg),
        .wdata_i  (bus.wb_write_data)
    );

    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);

    assign load_use = valid_q && bus.ex_MemRead && hazard_match(bus.ex_write_reg, rs, rt);

    // beq compares in ID, so it must also wait for any ALU result still in EX and any load in MEM.
    assign branch_hazard = valid_q && is_beq &&
                           ((bus.ex_RegWrite  && hazard_match(bus.ex_write_reg,  rs, rt)) ||
                            (bus.mem_MemRead  && hazard_match(bus.mem_write_reg, rs, rt)));

    assign stall       = load_use || branch_hazard;
    assign take_branch = valid_q && !stall && is_beq && (rd1 == rd2);
    assign take_jump   = valid_q && !stall && is_j;
    assign flush       = take_branch || take_jump;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush) begin
            inst_d  = RESET_INST;
            valid_d = 1'b0;
        end else if (!stall) begin
            inst_d  = bus.r_data;
            pc_d    = bus.pc_add_out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q  <= RESET_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.PCWrite    = !stall;
    assign bus.PCSrc      = take_branch;
    assign bus.Jump       = take_jump;
    assign bus.id_bubble  = stall || !valid_q;
    assign bus.branch_add = pc_q + {imm_ext[29:0], 2'b00};
    assign bus.jump_add   = {pc_q[31:28], target, 2'b00};
    assign bus.id_pc_add  = pc_q;
    assign bus.id_inst    = inst_q;
    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.sign_ext   = imm_ext;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_stage;

    localparam logic [31:0] RST_INST = 32'h0000_0000;
`ifdef ID_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage #(.RESET_INST(RST_INST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_inst, m_pc;
    logic        m_valid;
    logic [31:0] m_regs [32];

    function automatic logic [4:0] m_rs();
        return 5'((m_inst >> 21) % 32);
    endfunction
    function automatic logic [4:0] m_rt();
        return 5'((m_inst >> 16) % 32);
    endfunction
    function automatic logic [5:0] m_op();
        return 6'(m_inst / 32'h0400_0000);
    endfunction
    function automatic logic [31:0] m_sext();
        logic [31:0] imm;
        imm = m_inst % 32'h0001_0000;
        return (imm < 32'h8000) ? imm : imm + 32'hFFFF_0000;
    endfunction
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && bus.wb_RegWrite && bus.wb_write_reg == a) return bus.wb_write_data;
        return m_regs[a];
    endfunction
    function automatic bit m_uses(input logic [4:0] d);
        return (d != 5'd0) && (d == m_rs() || d == m_rt());
    endfunction
    function automatic bit m_stall();
        bit lu, br;
        lu = m_valid && bus.ex_MemRead && m_uses(bus.ex_write_reg);
        br = m_valid && (m_op() == 6'd4) &&
             ((bus.ex_RegWrite && m_uses(bus.ex_write_reg)) ||
              (bus.mem_MemRead && m_uses(bus.mem_write_reg)));
        return lu || br;
    endfunction
    function automatic bit m_pcsrc();
        return m_valid && !m_stall() && (m_op() == 6'd4) && (m_read(m_rs()) == m_read(m_rt()));
    endfunction
    function automatic bit m_jump();
        return m_valid && !m_stall() && (m_op() == 6'd2);
    endfunction
    function automatic logic [31:0] m_branch();
        return m_pc + 32'd4 * m_sext();
    endfunction
    function automatic logic [31:0] m_jaddr();
        return (m_pc / 32'h1000_0000) * 32'h1000_0000 + (m_inst % 32'h0400_0000) * 32'd4;
    endfunction

    task automatic model_reset();
        m_inst  = RST_INST;
        m_pc    = 32'd0;
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    task automatic clear_inputs();
        bus.pc_add_out    = 32'd0;
        bus.r_data        = 32'd0;
        bus.wb_RegWrite   = 1'b0;
        bus.wb_write_reg  = 5'd0;
        bus.wb_write_data = 32'd0;
        bus.ex_RegWrite   = 1'b0;
        bus.ex_MemRead    = 1'b0;
        bus.ex_write_reg  = 5'd0;
        bus.mem_MemRead   = 1'b0;
        bus.mem_write_reg = 5'd0;
    endtask

    // One clock edge; the model advances with the same inputs the DUT sees.
    task automatic step();
        bit          fl, st, we;
        logic [4:0]  wa;
        logic [31:0] wd, ri, rp;
        fl = m_pcsrc() || m_jump();
        st = m_stall();
        we = bus.wb_RegWrite; wa = bus.wb_write_reg; wd = bus.wb_write_data;
        ri = bus.r_data; rp = bus.pc_add_out;
        @(posedge clk);
        if (fl) begin
            m_inst = RST_INST; m_valid = 1'b0;
        end else if (!st) begin
            m_inst = ri; m_pc = rp; m_valid = 1'b1;
        end
        if (we && wa != 5'd0) m_regs[wa] = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        vectors++;
        if ({bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_ctl got=%b want=1001", {bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble});
        end
        vectors++;
        if (bus.branch_add !== 32'd0 || bus.jump_add !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_targets got=%h/%h want=0/0", bus.branch_add, bus.jump_add);
        end
        vectors++;
        if (bus.id_inst !== RST_INST || bus.id_pc_add !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_ifid got=%h/%h want=%h/0", bus.id_inst, bus.id_pc_add, RST_INST);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_load();
        bus.r_data = 32'h8C22_0004; bus.pc_add_out = 32'd4;
        step();
        bus.r_data = 32'd0;
        #1;
        vectors++;
        if (bus.id_inst !== 32'h8C22_0004 || bus.id_pc_add !== 32'd4 || bus.id_bubble !== 1'b0) begin
            miscompares++;
            $display("FAIL first_load got=%h/%h/%b want=8c220004/4/0", bus.id_inst, bus.id_pc_add, bus.id_bubble);
        end
        $display("load: id_inst=%h id_pc_add=%h", bus.id_inst, bus.id_pc_add);
    endtask

    task automatic test_load_use();
        bus.r_data = 32'h8C41_0000; bus.pc_add_out = 32'd8;
        step();
        bus.ex_MemRead = 1'b1; bus.ex_write_reg = 5'd0; bus.r_data = 32'd0; bus.pc_add_out = 32'hC;
        #1;
        vectors++;
        if (bus.PCWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_r0 got=%b want=1", bus.PCWrite);
        end
        bus.ex_write_reg = 5'd2;
        #1;
        vectors++;
        if (bus.PCWrite !== 1'b0 || bus.id_bubble !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_stall got=%b/%b want=0/1", bus.PCWrite, bus.id_bubble);
        end
        step();
        vectors++;
        if (bus.id_inst !== 32'h8C41_0000 || bus.id_pc_add !== 32'd8) begin
            miscompares++;
            $display("FAIL load_use_hold got=%h/%h want=8c410000/8", bus.id_inst, bus.id_pc_add);
        end
        bus.ex_MemRead = 1'b0;
        #1;
        vectors++;
        if (bus.PCWrite !== 1'b1 || bus.id_bubble !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_release got=%b/%b want=1/0", bus.PCWrite, bus.id_bubble);
        end
        step();
        clear_inputs();
        $display("load_use: stall and release done");
    endtask

    task automatic test_branch();
        bus.wb_RegWrite = 1'b1; bus.wb_write_reg = 5'd1; bus.wb_write_data = 32'd5;
        step();
        bus.wb_write_reg = 5'd2;
        step();
        clear_inputs();
        bus.r_data = 32'h1022_0003; bus.pc_add_out = 32'h10;
        step();
        bus.r_data = 32'hAAAA_AAAA;
        bus.ex_RegWrite = 1'b1; bus.ex_write_reg = 5'd2;
        #1;
        vectors++;
        if (bus.PCSrc !== 1'b0 || bus.PCWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_hazard got=%b/%b want=0/0", bus.PCSrc, bus.PCWrite);
        end
        bus.ex_RegWrite = 1'b0;
        #1;
        vectors++;
        if (bus.PCSrc !== 1'b1 || bus.branch_add !== 32'h1C) begin
            miscompares++;
            $display("FAIL branch_taken got=%b/%h want=1/0000001c", bus.PCSrc, bus.branch_add);
        end
        step();
        vectors++;
        if (bus.id_inst !== RST_INST || bus.id_bubble !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_flush got=%h/%b want=%h/1", bus.id_inst, bus.id_bubble, RST_INST);
        end
        clear_inputs();
        $display("branch: target=0000001c flushed");
    endtask

    task automatic test_jump();
        bus.r_data = 32'h0800_0040; bus.pc_add_out = 32'h8000_0008;
        step();
        bus.r_data = 32'h5555_5555;
        #1;
        vectors++;
        if (bus.Jump !== 1'b1 || bus.jump_add !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL jump got=%b/%h want=1/80000100", bus.Jump, bus.jump_add);
        end
        step();
        vectors++;
        if (bus.id_inst !== RST_INST || bus.id_bubble !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_flush got=%h/%b want=%h/1", bus.id_inst, bus.id_bubble, RST_INST);
        end
        clear_inputs();
        $display("jump: target=80000100 flushed");
    endtask

    task automatic test_wb_bypass();
        bus.wb_RegWrite = 1'b1; bus.wb_write_reg = 5'd3; bus.wb_write_data = 32'h1234;
        bus.r_data = 32'h0060_0000;
        step();
        bus.wb_RegWrite = 1'b0;
        #1;
        vectors++;
        if (bus.read_data1 !== 32'h1234) begin
            miscompares++;
            $display("FAIL wb_old got=%h want=00001234", bus.read_data1);
        end
        bus.wb_RegWrite = 1'b1; bus.wb_write_data = 32'hDEAD;
        #1;
        vectors++;
        if (bus.read_data1 !== (BYPASS ? 32'hDEAD : 32'h1234)) begin
            miscompares++;
            $display("FAIL wb_same_cycle got=%h want=%h", bus.read_data1, BYPASS ? 32'hDEAD : 32'h1234);
        end
        step();
        bus.wb_RegWrite = 1'b0; bus.r_data = 32'd0;
        #1;
        vectors++;
        if (bus.read_data1 !== 32'hDEAD) begin
            miscompares++;
            $display("FAIL wb_next_cycle got=%h want=0000dead", bus.read_data1);
        end
        step();
        bus.wb_RegWrite = 1'b1; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'hFFFF;
        #1;
        vectors++;
        if (bus.read_data1 !== 32'd0 || bus.read_data2 !== 32'd0) begin
            miscompares++;
            $display("FAIL wb_r0_same got=%h/%h want=0/0", bus.read_data1, bus.read_data2);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (bus.read_data1 !== 32'd0) begin
            miscompares++;
            $display("FAIL wb_r0_after got=%h want=0", bus.read_data1);
        end
        $display("wb_bypass: bypass=%0d done", BYPASS);
    endtask

    task automatic test_reset_mid_stall();
        bus.r_data = 32'h8C41_0000; bus.pc_add_out = 32'h30;
        step();
        bus.ex_MemRead = 1'b1; bus.ex_write_reg = 5'd2;
        #1;
        vectors++;
        if (bus.PCWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_stall got=%b want=0", bus.PCWrite);
        end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble} !== 4'b1001 || bus.id_inst !== RST_INST) begin
            miscompares++;
            $display("FAIL reset_mid_stall got=%b/%h want=1001/%h",
                     {bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble}, bus.id_inst, RST_INST);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.r_data = 32'h0020_0000; bus.pc_add_out = 32'h40;
        step();
        vectors++;
        if (bus.id_inst !== 32'h0020_0000 || bus.id_pc_add !== 32'h40 || bus.read_data1 !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_load got=%h/%h/%h want=00200000/40/0",
                     bus.id_inst, bus.id_pc_add, bus.read_data1);
        end
        clear_inputs();
        $display("reset_mid_stall: registers cleared, first load normal");
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [31:0] inst;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: inst = 32'h1000_0000 | (32'(pick_reg()) << 21) | (32'(pick_reg()) << 16) | ($urandom % 32'h10000);
                1: inst = 32'h0800_0000 | ($urandom % 32'h0400_0000);
                2: inst = 32'h8C00_0000 | (32'(pick_reg()) << 21) | (32'(pick_reg()) << 16) | ($urandom % 32'h10000);
                default: inst = $urandom;
            endcase
            bus.r_data        = inst;
            bus.pc_add_out    = $urandom;
            bus.wb_RegWrite   = 1'($urandom_range(0, 1));
            bus.wb_write_reg  = pick_reg();
            bus.wb_write_data = ($urandom_range(0, 2) == 0) ? $urandom : 32'(5 + 2 * $urandom_range(0, 1));
            bus.ex_RegWrite   = ($urandom_range(0, 3) == 0);
            bus.ex_MemRead    = ($urandom_range(0, 3) == 0);
            bus.ex_write_reg  = pick_reg();
            bus.mem_MemRead   = ($urandom_range(0, 3) == 0);
            bus.mem_write_reg = pick_reg();
            #1;
            vectors++;
            if ({bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble} !==
                {!m_stall(), m_pcsrc(), m_jump(), m_stall() || !m_valid}) begin
                miscompares++;
                $display("FAIL rand_ctl[%0d] got=%b want=%b", n,
                         {bus.PCWrite, bus.PCSrc, bus.Jump, bus.id_bubble},
                         {!m_stall(), m_pcsrc(), m_jump(), m_stall() || !m_valid});
            end
            vectors++;
            if (bus.id_inst !== m_inst || bus.id_pc_add !== m_pc) begin
                miscompares++;
                $display("FAIL rand_ifid[%0d] got=%h/%h want=%h/%h", n, bus.id_inst, bus.id_pc_add, m_inst, m_pc);
            end
            vectors++;
            if (bus.read_data1 !== m_read(m_rs()) || bus.read_data2 !== m_read(m_rt())) begin
                miscompares++;
                $display("FAIL rand_read[%0d] got=%h/%h want=%h/%h", n, bus.read_data1, bus.read_data2,
                         m_read(m_rs()), m_read(m_rt()));
            end
            vectors++;
            if (bus.sign_ext !== m_sext() || bus.branch_add !== m_branch() || bus.jump_add !== m_jaddr()) begin
                miscompares++;
                $display("FAIL rand_addr[%0d] got=%h/%h/%h want=%h/%h/%h", n, bus.sign_ext, bus.branch_add,
                         bus.jump_add, m_sext(), m_branch(), m_jaddr());
            end
            $display("rand[%0d]: inst=%h stall=%0d pcsrc=%0d jump=%0d", n, m_inst, m_stall(), m_pcsrc(), m_jump());
            step();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_use();
        test_branch();
        test_jump();
        test_wb_bypass();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
